cla_8bit_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `cla_8bit` adder between `N_REQ` requesters. Each requester offers an 8-bit operand pair over a valid/ready handshake. The block grants one requester at a time and registers the operands into the shared adder. It returns the 9-bit sum, tagged with the requester index, over a valid/ready response channel with backpressure. The block sits between client blocks and the single CLA datapath instance.

---
 rtl/cla_8bit_arb_pkg.sv | 34 +++
 rtl/cla_8bit_arb_if.sv | 27 ++
 rtl/cla_8bit_arb_cla.sv | 40 ++++
 rtl/cla_8bit_arb.sv | 91 +++++++++
 tb/tb_cla_8bit_arb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cla_8bit_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the CLA arbiter.
package cla_arb_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} cla_arb_state_t;

  localparam int OPW     = 8;
  localparam int SUMW    = 9;
  localparam int MAX_REQ = 4;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Searches from last+1 upward, wrapping modulo n; first valid requester wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [1:0]         last,
                                       input int unsigned        n);
    rr_pick_t   r;
    logic [1:0] cand;
    r = '0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      if (off <= n) begin
        cand = 2'((32'(last) + off) % n);
        if (!r.found && valid[cand]) begin
          r.found = 1'b1;
          r.idx   = cand;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_8bit_arb_if.sv
// Requester and response channels between client blocks and the CLA arbiter.
interface cla_8bit_arb_if #(
  parameter int N_REQ = 2,
  parameter int IDW   = $clog2(N_REQ)
);
  import cla_arb_pkg::*;

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0][OPW-1:0]  req_a;
  logic [N_REQ-1:0][OPW-1:0]  req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [SUMW-1:0]            rsp_sum;
  logic [IDW-1:0]             rsp_id;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );
endinterface

// File: rtl/cla_8bit_arb_cla.sv
// 8-bit carry-lookahead adder: two 4-bit lookahead groups with a group-level carry stage.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [1:0] w_gg;
  logic [1:0] w_gp;
  logic [1:0] w_gc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign cout    = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);

  for (genvar n = 0; n < 2; n++) begin : g_nib
    localparam int B = n * 4;
    logic [3:0] w_ci;

    assign w_gg[n] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_gp[n] = &w_p[B+3:B];

    // Carries expanded from the group carry-in so no bit depends on a sibling carry.
    assign w_ci[0] = w_gc[n];
    assign w_ci[1] = w_g[B] | (w_p[B] & w_gc[n]);
    assign w_ci[2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[n]);
    assign w_ci[3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                   | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[n]);

    assign sum[B+3:B] = w_p[B+3:B] ^ w_ci;
  end

endmodule

// File: rtl/cla_8bit_arb.sv
// Round-robin arbiter sharing one cla_8bit between N_REQ requesters; one operation in flight.
module cla_8bit_arb
  import cla_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = $clog2(N_REQ)
) (
  input logic          clk,
  input logic          rst_n,
  cla_8bit_arb_if.slave bus
);

  cla_arb_state_t     r_state;
  logic [IDW-1:0]     r_last_grant;
  logic [IDW-1:0]     r_op_id;
  logic [OPW-1:0]     r_op_a;
  logic [OPW-1:0]     r_op_b;
  logic [SUMW-1:0]    r_rsp_sum;
  logic [IDW-1:0]     r_rsp_id;

  logic [MAX_REQ-1:0] w_valid_ext;
  logic [1:0]         w_last_ext;
  rr_pick_t           w_pick;
  logic [IDW-1:0]     w_gnt_id;
  logic               w_grant;
  logic [OPW-1:0]     w_cla_sum;
  logic               w_cla_cout;

  // Grant is masked while reset is held so no requester sees ready during reset.
  always_comb begin
    w_valid_ext              = '0;
    w_valid_ext[N_REQ-1:0]   = bus.req_valid;
    w_last_ext               = '0;
    w_last_ext[IDW-1:0]      = r_last_grant;
    w_pick                   = rr_pick(w_valid_ext, w_last_ext, N_REQ);
    w_gnt_id                 = IDW'(w_pick.idx);
    w_grant                  = (r_state == IDLE) && w_pick.found && rst_n;
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_grant) bus.req_ready[w_gnt_id] = 1'b1;
  end

  assign bus.rsp_valid = (r_state == RESP);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_id    = r_rsp_id;

  cla_8bit u_cla (
    .a   (r_op_a),
    .b   (r_op_b),
    .cin (1'b0),
    .sum (w_cla_sum),
    .cout(w_cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= IDW'(N_REQ - 1);
      r_op_id      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rsp_sum    <= '0;
      r_rsp_id     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_op_a       <= bus.req_a[w_gnt_id];
            r_op_b       <= bus.req_b[w_gnt_id];
            r_op_id      <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_rsp_sum <= {w_cla_cout, w_cla_sum};
          r_rsp_id  <= r_op_id;
          r_state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_8bit_arb.sv
// Scoreboard bench for cla_8bit_arb: grant and response monitors check directed vectors.
module tb_cla_8bit_arb;
  import cla_arb_pkg::*;

  localparam int N = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_8bit_arb_if #(.N_REQ(N)) bus();

  cla_8bit_arb #(.N_REQ(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int id;
    int sum;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   exp_tbl[N];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   n_grants = 0;
  int   cyc      = 0;
  int   gm_g;
  logic seen     = 1'b0;
  int   hold_sum;
  int   hold_id;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Grant monitor: each visible grant consumes the next expected grant and queues its result.
  always @(negedge clk) begin
    if (rst_n && bus.req_ready != '0) begin
      n_grants++;
      if (gq.size() == 0) begin
        flag("unexpected_grant", $sformatf("got req_ready=%b, expected none", bus.req_ready));
      end else begin
        gm_g = gq.pop_front();
        chk("grant", int'(bus.req_ready), 1 << gm_g);
        sb.push_back('{gm_g, exp_tbl[gm_g], cyc});
      end
    end
  end

  // Response monitor: latency, stability under backpressure, and result on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        flag("unexpected_rsp", $sformatf("got sum=%0d id=%0d, expected no response",
                                         bus.rsp_sum, bus.rsp_id));
      end else begin
        if (!seen) begin
          seen     = 1'b1;
          chk("latency", cyc - sb[0].cyc, 2);
          hold_sum = int'(bus.rsp_sum);
          hold_id  = int'(bus.rsp_id);
        end else begin
          chk("stall_sum_stable", int'(bus.rsp_sum), hold_sum);
          chk("stall_id_stable", int'(bus.rsp_id), hold_id);
        end
        if (bus.rsp_ready) begin
          chk("rsp_id", int'(bus.rsp_id), sb[0].id);
          chk("rsp_sum", int'(bus.rsp_sum), sb[0].sum);
          void'(sb.pop_front());
          seen = 1'b0;
        end else begin
          chk("stall_req_ready", int'(bus.req_ready), 0);
          chk("stall_busy", int'(bus.busy), 1);
        end
      end
    end
  end

  task automatic wait_grants(input int target);
    int t = 0;
    while (n_grants < target && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (n_grants < target)
      flag("grant_timeout", $sformatf("got %0d grants, expected %0d", n_grants, target));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || bus.busy) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0 || bus.busy)
      flag("idle_timeout", $sformatf("got %0d pending results busy=%0d, expected 0 and 0",
                                     sb.size(), bus.busy));
  endtask

  task automatic op(input int id, input int a, input int b, input int exp);
    gq.push_back(id);
    exp_tbl[id]          = exp;
    bus.req_a[id]        = 8'(a);
    bus.req_b[id]        = 8'(b);
    bus.req_valid[id]    = 1'b1;
    wait_grants(n_grants + 1);
    bus.req_valid[id]    = 1'b0;
    wait_idle();
  endtask

  initial begin
    int t;
    int tgt;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    exp_tbl       = '{default: 0};

    // Reset with both requesters valid
    bus.req_a[0] = 8'd1;  bus.req_b[0] = 8'd2;  exp_tbl[0] = 3;
    bus.req_a[1] = 8'd9;  bus.req_b[1] = 8'd9;  exp_tbl[1] = 18;
    bus.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", int'(bus.req_ready), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_sum", int'(bus.rsp_sum), 0);
    chk("reset_rsp_id", int'(bus.rsp_id), 0);
    chk("reset_busy", int'(bus.busy), 0);
    gq.push_back(0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_grants(n_grants + 1);
    bus.req_valid = '0;
    wait_idle();

    // Single request and carry boundaries
    op(1, 6, 5, 11);
    op(0, 255, 1, 256);
    op(0, 0, 0, 0);
    op(1, 255, 255, 510);

    // Fairness: both valid for six operations
    bus.req_a[0] = 8'd10;  bus.req_b[0] = 8'd20;  exp_tbl[0] = 30;
    bus.req_a[1] = 8'd100; bus.req_b[1] = 8'd200; exp_tbl[1] = 300;
    for (int i = 0; i < 6; i++) gq.push_back(i % 2);
    bus.req_valid = 2'b11;
    wait_grants(n_grants + 6);
    bus.req_valid = '0;
    wait_idle();

    // Backpressure with a second request pending
    bus.rsp_ready = 1'b0;
    gq.push_back(1);
    exp_tbl[1] = 15; bus.req_a[1] = 8'd7; bus.req_b[1] = 8'd8;
    bus.req_valid[1] = 1'b1;
    wait_grants(n_grants + 1);
    bus.req_valid[1] = 1'b0;
    gq.push_back(0);
    exp_tbl[0] = 110; bus.req_a[0] = 8'd50; bus.req_b[0] = 8'd60;
    bus.req_valid[0] = 1'b1;
    t = 0;
    while (!bus.rsp_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.rsp_valid) flag("bp_rsp_timeout", "got rsp_valid=0, expected 1");
    repeat (10) begin
      @(posedge clk); #1;
    end
    tgt = n_grants + 1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_regrant", int'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    chk("bp_grant_count", n_grants, tgt);
    wait_idle();

    // Reset during CALC
    gq.push_back(0);
    exp_tbl[0] = 77; bus.req_a[0] = 8'd70; bus.req_b[0] = 8'd7;
    bus.req_valid[0] = 1'b1;
    wait_grants(n_grants + 1);
    bus.req_valid[0] = 1'b0;
    chk("midop_in_calc", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midop_busy", int'(bus.busy), 0);
    chk("midop_rsp_sum", int'(bus.rsp_sum), 0);
    chk("midop_req_ready", int'(bus.req_ready), 0);
    sb.delete();
    gq.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midop_quiet_busy", int'(bus.busy), 0);
    gq.push_back(0);
    exp_tbl[0] = 40; bus.req_a[0] = 8'd15; bus.req_b[0] = 8'd25;
    exp_tbl[1] = 2;  bus.req_a[1] = 8'd1;  bus.req_b[1] = 8'd1;
    bus.req_valid = 2'b11;
    wait_grants(n_grants + 1);
    bus.req_valid = '0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
